// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID word, then build timestamp),
// compares both against expected constants and reports the result before CPU release.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'd1476908497,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned RETRY_LIMIT    = 2,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    R_MAX  = 4'(RETRY_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_ID,
      S_WAIT_ID,
      S_REQ_TS,
      S_WAIT_TS,
      S_CMP,
      S_DONE
   } state_t;

   state_t        state, state_nx;
   logic          auto_pend;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic [3:0]    retry_cnt, retry_nx;
   logic          read_nx, address_nx;
   logic          done_nx, id_ok_nx, ts_ok_nx, timeout_err_nx;
   logic [31:0]   id_value_nx, ts_value_nx;
   logic          is_ts;

   assign busy  = (state != S_IDLE) && (state != S_DONE);
   assign is_ts = (state == S_REQ_TS) || (state == S_WAIT_TS);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      tcnt_nx        = tcnt;
      retry_nx       = retry_cnt;
      done_nx        = done;
      id_ok_nx       = id_ok;
      ts_ok_nx       = ts_ok;
      timeout_err_nx = timeout_err;
      id_value_nx    = id_value;
      ts_value_nx    = ts_value;
      address_nx     = avm_address;

      unique case (state)
         S_IDLE: begin
            if (start || auto_pend) begin
               state_nx = S_REQ_ID;
               retry_nx = '0;
            end
         end
         S_REQ_ID, S_REQ_TS: begin
            if (!avm_waitrequest) begin
               tcnt_nx = '0;
               // a zero-latency slave answers in the acceptance cycle: skip the WAIT state
               if (avm_readdatavalid) begin
                  if (is_ts) ts_value_nx = avm_readdata;
                  else       id_value_nx = avm_readdata;
                  state_nx = is_ts ? S_CMP : S_REQ_TS;
               end else begin
                  state_nx = is_ts ? S_WAIT_TS : S_WAIT_ID;
               end
            end
         end
         S_WAIT_ID, S_WAIT_TS: begin
            if (avm_readdatavalid) begin
               if (is_ts) ts_value_nx = avm_readdata;
               else       id_value_nx = avm_readdata;
               state_nx = is_ts ? S_CMP : S_REQ_TS;
            end else if (tcnt == T_LAST) begin
               if (retry_cnt < R_MAX) begin
                  retry_nx = retry_cnt + 4'd1;
                  state_nx = is_ts ? S_REQ_TS : S_REQ_ID;
               end else begin
                  timeout_err_nx = 1'b1;
                  id_ok_nx       = 1'b0;
                  ts_ok_nx       = 1'b0;
                  state_nx       = S_DONE;
               end
            end else begin
               tcnt_nx = tcnt + TW'(1);
            end
         end
         S_CMP: begin
            id_ok_nx = (id_value == EXPECTED_ID);
            ts_ok_nx = (ts_value == EXPECTED_TS);
            state_nx = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               state_nx       = S_REQ_ID;
               retry_nx       = '0;
               id_ok_nx       = 1'b0;
               ts_ok_nx       = 1'b0;
               timeout_err_nx = 1'b0;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // bus request is registered from the next state so it is already valid on REQ entry
      read_nx = (state_nx == S_REQ_ID) || (state_nx == S_REQ_TS);
      if (state_nx == S_REQ_ID) address_nx = 1'b0;
      if (state_nx == S_REQ_TS) address_nx = 1'b1;
      done_nx = (state_nx == S_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         auto_pend   <= AUTO_START;
         tcnt        <= '0;
         retry_cnt   <= '0;
         avm_read    <= 1'b0;
         avm_address <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout_err <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         auto_pend   <= 1'b0;
         tcnt        <= tcnt_nx;
         retry_cnt   <= retry_nx;
         avm_read    <= read_nx;
         avm_address <= address_nx;
         done        <= done_nx;
         id_ok       <= id_ok_nx;
         ts_ok       <= ts_ok_nx;
         timeout_err <= timeout_err_nx;
         id_value    <= id_value_nx;
         ts_value    <= ts_value_nx;
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: reactive Avalon slave with configurable stall/latency/silence
// and an outcome model (results, read count, address order, completion cycle).
module tb_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam logic [31:0] EXP_TS = 32'd1476908497;
   localparam int T      = 16;
   localparam int R      = 2;
   localparam int BUDGET = 400;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        avm_address, avm_read;
   logic        avm_waitrequest, avm_readdatavalid;
   logic [31:0] avm_readdata;
   logic        busy, done, id_ok, ts_ok, timeout_err;
   logic [31:0] id_value, ts_value;

   sysid_checker #(
      .EXPECTED_ID   (EXP_ID),
      .EXPECTED_TS   (EXP_TS),
      .TIMEOUT_CYCLES(T),
      .RETRY_LIMIT   (R),
      .AUTO_START    (1'b1)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .avm_address      (avm_address),
      .avm_read         (avm_read),
      .avm_waitrequest  (avm_waitrequest),
      .avm_readdata     (avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .busy             (busy),
      .done             (done),
      .id_ok            (id_ok),
      .ts_ok            (ts_ok),
      .timeout_err      (timeout_err),
      .id_value         (id_value),
      .ts_value         (ts_value)
   );

   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;

   // slave behaviour for the current check
   logic [31:0] cfg_id = EXP_ID;
   logic [31:0] cfg_ts = EXP_TS;
   int          cfg_wait = 0;
   int          cfg_lat  = 1;
   bit          cfg_mute = 1'b0;

   int   accepts = 0;
   int   acc_addr[$];
   // values the model believes the DUT is holding
   logic [31:0] m_id = '0;
   logic [31:0] m_ts = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // slave: decides waitrequest/readdatavalid at each falling edge for the next rising edge
   initial begin : slave
      int   neg_n;
      bit   pend, in_req, stalled_prev;
      int   pend_at, stall_left;
      logic [31:0] pend_data;
      logic addr_prev;
      neg_n = 0; pend = 0; in_req = 0; stalled_prev = 0; pend_at = 0; stall_left = 0;
      pend_data = '0; addr_prev = 1'b0;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
      forever begin
         @(negedge clock);
         neg_n++;
         avm_waitrequest   = 1'b0;
         avm_readdatavalid = 1'b0;
         avm_readdata      = $urandom;
         if (reset) begin
            pend = 0; in_req = 0; stalled_prev = 0;
         end else begin
            if (stalled_prev) begin
               chk("stall_hold_read", 32'(avm_read), 32'd1);
               chk("stall_hold_addr", 32'(avm_address), 32'(addr_prev));
            end
            stalled_prev = 0;
            if (avm_read) begin
               if (!in_req) begin
                  in_req = 1; stall_left = cfg_wait;
               end
               if (stall_left > 0) begin
                  stall_left--;
                  avm_waitrequest = 1'b1;
                  stalled_prev = 1;
                  addr_prev = avm_address;
               end else begin
                  in_req = 0;
                  accepts++;
                  acc_addr.push_back(int'(avm_address));
                  if (!cfg_mute) begin
                     pend = 1;
                     pend_at = neg_n + cfg_lat;
                     pend_data = avm_address ? cfg_ts : cfg_id;
                  end
               end
            end
            if (pend && pend_at == neg_n) begin
               avm_readdatavalid = 1'b1;
               avm_readdata = pend_data;
               pend = 0;
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_id_ok"}, 32'(id_ok), 32'd0);
      chk({tag, "_ts_ok"}, 32'(ts_ok), 32'd0);
      chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
      chk({tag, "_read"}, 32'(avm_read), 32'd0);
      chk({tag, "_addr"}, 32'(avm_address), 32'd0);
      chk({tag, "_id_value"}, id_value, 32'd0);
      chk({tag, "_ts_value"}, ts_value, 32'd0);
   endtask

   // Caller has just raised start (or released reset) at a falling edge: that cycle is cycle 0.
   task automatic run_check(input string tag, input bit poke_busy);
      int cyc, exp_cyc, exp_acc;
      bit exp_to, exp_idok, exp_tsok;
      cyc = 0;
      if (cfg_mute) begin
         exp_to = 1; exp_idok = 0; exp_tsok = 0;
         exp_acc = R + 1;
         exp_cyc = 1 + (R + 1) * (1 + cfg_wait + T);
      end else begin
         exp_to = 0;
         exp_acc = 2;
         m_id = cfg_id;
         m_ts = cfg_ts;
         exp_idok = (cfg_id == EXP_ID);
         exp_tsok = (cfg_ts == EXP_TS);
         exp_cyc = 4 + 2 * cfg_wait + 2 * cfg_lat;
      end
      accepts = 0;
      acc_addr.delete();
      while (cyc < BUDGET) begin
         @(negedge clock);
         cyc++;
         start = 1'b0;
         if (cyc == 1) begin
            chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
            chk({tag, "_done_clr"}, 32'(done), 32'd0);
            chk({tag, "_to_clr"}, 32'(timeout_err), 32'd0);
         end
         if (poke_busy && cyc == 2) start = 1'b1;
         if (done) break;
      end
      chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_id_ok"}, 32'(id_ok), 32'(exp_idok));
      chk({tag, "_ts_ok"}, 32'(ts_ok), 32'(exp_tsok));
      chk({tag, "_timeout"}, 32'(timeout_err), 32'(exp_to));
      chk({tag, "_id_value"}, id_value, m_id);
      chk({tag, "_ts_value"}, ts_value, m_ts);
      chk({tag, "_accepts"}, 32'(accepts), 32'(exp_acc));
      for (int i = 0; i < exp_acc; i++) begin
         int a;
         a = (i < acc_addr.size()) ? acc_addr[i] : -1;
         chk({tag, "_addr_seq"}, 32'(a), cfg_mute ? 32'd0 : 32'(i));
      end
      repeat (3) @(negedge clock);
      chk({tag, "_done_hold"}, 32'(done), 32'd1);
      chk({tag, "_no_extra_read"}, 32'(accepts), 32'(exp_acc));
   endtask

   initial begin : main
      repeat (3) @(negedge clock);
      check_all_zero("rst");

      // 1: auto start after reset release, nominal slave
      reset = 1'b0;
      run_check("t1_auto", 1'b0);

      // 2: wrong timestamp
      cfg_ts = 32'h1234_5678;
      start = 1'b1;
      run_check("t2_bad_ts", 1'b0);

      // 3: long stalls on each request
      cfg_ts = EXP_TS;
      cfg_wait = 10;
      start = 1'b1;
      run_check("t3_stall", 1'b0);

      // 4: silent slave, retries then timeout
      cfg_wait = 0;
      cfg_mute = 1'b1;
      start = 1'b1;
      run_check("t4_timeout", 1'b0);

      // 5: combinational slave
      cfg_mute = 1'b0;
      cfg_lat = 0;
      start = 1'b1;
      run_check("t5_zero_lat", 1'b0);

      // 6: reset during WAIT_TS, then a clean check with a start pulse while busy
      cfg_lat = 3;
      cfg_id = 32'hDEAD_0001;
      start = 1'b1;
      accepts = 0;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      chk("t6_busy_before_rst", 32'(busy), 32'd1);
      chk("t6_accepts_before_rst", 32'(accepts), 32'd2);
      #2 reset = 1'b1;
      #1 check_all_zero("t6_async_rst");
      m_id = '0;
      m_ts = '0;
      repeat (2) @(negedge clock);
      cfg_lat = 1;
      cfg_id = EXP_ID;
      reset = 1'b0;
      run_check("t6_fresh", 1'b1);

      // randomized checks
      for (int n = 0; n < 12; n++) begin
         cfg_id   = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
         cfg_ts   = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
         cfg_wait = int'($urandom_range(0, 3));
         cfg_lat  = int'($urandom_range(0, 4));
         cfg_mute = ($urandom_range(0, 5) == 0);
         start = 1'b1;
         run_check("rand", ($urandom_range(0, 1) == 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

endmodule
